// File: rtl/shift_exec.sv
// ---------------------------------------------------------------------------
// shift_exec -- serial shift execution unit for one calc2 port.
//
// Accepted shift commands are queued in a small FIFO. The FSM pops one at a
// time, shifts the operand one bit per clock edge and then presents the
// result on shift_data/shift_resp/shift_tag. The response is held for as long
// as the adder is responding on the same port. All state changes on the
// falling edge of c_clk. reset is asynchronous and active-high.
//
// Optional feature macro: SHIFT_EXEC_ROTATE_EN
//   defined   : cmd 0111 (rotate left) and 1000 (rotate right) are executed.
//   undefined : those codes are consumed and dropped like any other non-shift.
//
// Parameters
//   FIFO_DEPTH  pending-command queue depth (2 or 4; must be a power of two)
//   AMT_W       shift-amount width, taken from the low bits of op2
//
// Ports
//   c_clk       clock; state updates on the falling edge
//   reset       asynchronous active-high reset
//   cmd_valid   command present this cycle
//   cmd         command code (0101 shl, 0110 shr, 0111 rol, 1000 ror)
//   cmd_tag     tag returned with the response
//   op1         operand to shift
//   op2         shift amount in op2[AMT_W-1:0]; other bits ignored
//   cmd_ready   FIFO not full
//   adder_resp  adder response; non-zero holds our response
//   shift_data  result while responding, else 0
//   shift_resp  01 while responding, else 00
//   shift_tag   result tag while responding, else 00
//   busy        FSM not idle or FIFO not empty
// ---------------------------------------------------------------------------
module shift_exec #(
    parameter int FIFO_DEPTH = 2,
    parameter int AMT_W      = 5
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [3:0]  cmd,
    input  logic [1:0]  cmd_tag,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        cmd_ready,
    input  logic [1:0]  adder_resp,
    output logic [31:0] shift_data,
    output logic [1:0]  shift_resp,
    output logic [1:0]  shift_tag,
    output logic        busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [3:0] CMD_SHL = 4'b0101;
    localparam logic [3:0] CMD_SHR = 4'b0110;
`ifdef SHIFT_EXEC_ROTATE_EN
    localparam logic [3:0] CMD_ROL = 4'b0111;
    localparam logic [3:0] CMD_ROR = 4'b1000;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_RESP
    } state_t;

    // -----------------------------------------------------------------------
    // Command decode
    // -----------------------------------------------------------------------
    logic cmd_legal;
    logic op2_unused;

`ifdef SHIFT_EXEC_ROTATE_EN
    assign cmd_legal = (cmd == CMD_SHL) || (cmd == CMD_SHR) ||
                       (cmd == CMD_ROL) || (cmd == CMD_ROR);
`else
    assign cmd_legal = (cmd == CMD_SHL) || (cmd == CMD_SHR);
`endif

    assign op2_unused = ^op2[31:AMT_W];

    // One single-bit step of the working value for the given opcode.
    function automatic logic [31:0] step_one(input logic [31:0] d, input logic [3:0] op);
        logic [31:0] r;
        case (op)
            CMD_SHL: r = {d[30:0], 1'b0};
            CMD_SHR: r = {1'b0, d[31:1]};
`ifdef SHIFT_EXEC_ROTATE_EN
            CMD_ROL: r = {d[30:0], d[31]};
            CMD_ROR: r = {d[0], d[31:1]};
`endif
            default: r = d;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Pending-command FIFO
    // -----------------------------------------------------------------------
    logic [3:0]       fifo_cmd_q  [FIFO_DEPTH];
    logic [1:0]       fifo_tag_q  [FIFO_DEPTH];
    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    logic [AMT_W-1:0] fifo_amt_q  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    logic             fifo_empty;

    assign cmd_ready  = (count_q != DEPTH_C);
    assign fifo_empty = (count_q == '0);
    // Non-shift codes are consumed (cmd_ready still applies) but never stored.
    assign push       = cmd_valid && cmd_ready && cmd_legal;

    // Slot storage needs no reset: a slot is only read after it was written.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            always_ff @(negedge c_clk) begin
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    fifo_cmd_q[gi]  <= cmd;
                    fifo_tag_q[gi]  <= cmd_tag;
                    fifo_data_q[gi] <= op1;
                    fifo_amt_q[gi]  <= op2[AMT_W-1:0];
                end
            end
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(negedge c_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Execution FSM and working registers
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [31:0]      work_data_q, work_data_d;
    logic [1:0]       work_tag_q, work_tag_d;
    logic [AMT_W-1:0] work_cnt_q, work_cnt_d;
    logic [3:0]       work_cmd_q, work_cmd_d;

    always_comb begin
        state_d     = state_q;
        work_data_d = work_data_q;
        work_tag_d  = work_tag_q;
        work_cnt_d  = work_cnt_q;
        work_cmd_d  = work_cmd_q;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pop = !fifo_empty;
            end
            ST_SHIFT: begin
                work_data_d = step_one(work_data_q, work_cmd_q);
                work_cnt_d  = work_cnt_q - AMT_W'(1);
                if (work_cnt_q == AMT_W'(1)) state_d = ST_RESP;
            end
            ST_RESP: begin
                // Only leave once the adder has released the shared output.
                if (adder_resp == 2'b00) begin
                    if (fifo_empty) state_d = ST_IDLE;
                    else            pop     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A pop loads the head entry; a zero amount goes straight to RESP.
        if (pop) begin
            work_data_d = fifo_data_q[rd_ptr_q];
            work_tag_d  = fifo_tag_q[rd_ptr_q];
            work_cnt_d  = fifo_amt_q[rd_ptr_q];
            work_cmd_d  = fifo_cmd_q[rd_ptr_q];
            state_d     = (fifo_amt_q[rd_ptr_q] != '0) ? ST_SHIFT : ST_RESP;
        end
    end

    always_ff @(negedge c_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            work_data_q <= '0;
            work_tag_q  <= '0;
            work_cnt_q  <= '0;
            work_cmd_q  <= '0;
        end else begin
            state_q     <= state_d;
            work_data_q <= work_data_d;
            work_tag_q  <= work_tag_d;
            work_cnt_q  <= work_cnt_d;
            work_cmd_q  <= work_cmd_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: zero outside RESP because the downstream mux ORs the ports.
    // -----------------------------------------------------------------------
    logic resp_active;

    assign resp_active = (state_q == ST_RESP);
    assign shift_resp  = resp_active ? 2'b01 : 2'b00;
    assign shift_data  = resp_active ? work_data_q : 32'h0;
    assign shift_tag   = resp_active ? work_tag_q : 2'b00;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule
